vram_arbiter: RTL and testbench

Shares the single-port 12-bit image BRAM, addressed as {row[8:0], col[8:0]}, between two users. The VGA scan-out reader always has priority. An image-loader writer, fed by a UART or host path, is buffered in a small FIFO. Buffered writes drain into the BRAM only on cycles with no pixel read, in practice during blanking. The block sits between the display timing/address logic and the blk_mem_gen instance, all on the pixel clock.

---
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Shares one single-port image BRAM between the VGA scan-out reader
// (always wins) and a FIFO-buffered loader whose writes drain when no pixel is read.
//
// Ports:
//   clk, rst (sync, active-low)
//   pix_req/pix_addr    : display read request (never stalled)
//   pix_valid/pix_data  : returned pixel, 0 when not valid
//   wr_valid/wr_ready/wr_addr/wr_data : loader write handshake
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : registered BRAM port
//   fifo_level          : buffered writes
//   stall_cnt           : saturating count of blocked write cycles
module vram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_req,
  input  logic [ADDR_W-1:0]             pix_addr,
  output logic                          pix_valid,
  output logic [DATA_W-1:0]             pix_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   stall_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_faddr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fdata [FIFO_DEPTH];
  logic [PW:0]       r_wptr;
  logic [PW:0]       r_rptr;
  logic [MEM_LAT:0]  r_tag;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;
  logic [15:0]       r_stall;

  logic [PW:0]       w_level;
  logic              w_empty;
  logic              w_push;
  logic              w_gnt_rd;
  logic              w_gnt_wr;

  // Pointers carry one extra bit so full and empty differ.
  assign w_level  = r_wptr - r_rptr;
  assign w_empty  = (w_level == '0);
  assign wr_ready = rst & (w_level < LVL_FULL);
  assign w_push   = wr_valid & wr_ready;
  assign w_gnt_rd = pix_req;
  assign w_gnt_wr = ~pix_req & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_faddr[r_wptr[PW-1:0]] <= wr_addr;
      r_fdata[r_wptr[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_tag       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_stall     <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_gnt_wr)
        r_rptr <= r_rptr + 1'b1;
      // Tag bit k marks a read whose command went out k cycles ago.
      r_tag <= {r_tag[MEM_LAT-1:0], w_gnt_rd};
      if (w_gnt_rd) begin
        r_mem_en   <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= pix_addr;
      end else if (w_gnt_wr) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_faddr[r_rptr[PW-1:0]];
        r_mem_wdata <= r_fdata[r_rptr[PW-1:0]];
      end else begin
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
      end
      r_pix_valid <= r_tag[MEM_LAT];
      r_pix_data  <= r_tag[MEM_LAT] ? mem_rdata : '0;
      if (wr_valid && !wr_ready && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign fifo_level = w_level;
  assign stall_cnt  = r_stall;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: BRAM model, queue-based reference model,
// per-cycle compare plus directed literal checks.
module tb_vram_arbiter;

  localparam int AW  = 18;
  localparam int DW  = 12;
  localparam int DEP = 4;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_req;
  logic [AW-1:0] pix_addr;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    fifo_level;
  logic [15:0]   stall_cnt;

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEP), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;
  int cyc  = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // BRAM: one-cycle registered read, like blk_mem_gen without output reg.
  bit [DW-1:0] bram   [0:(1<<AW)-1];
  bit [DW-1:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  // Reference model: queue of buffered writes, shadow memory in issue
  // order, and a schedule of expected pixels keyed by cycle number.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } went_t;

  went_t         q[$];
  logic          e_en = 0;
  logic          e_we = 0;
  logic [AW-1:0] e_addr = 0;
  logic [DW-1:0] e_wd = 0;
  logic [15:0]   e_stall = 0;
  logic [DW-1:0] exp_pd[int];

  always @(posedge clk) begin : mdl
    int    t;
    went_t ent;
    bit    rdy;
    t = cyc;
    if (!rst) begin
      q.delete();
      exp_pd.delete();
      e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_stall = 0;
    end else begin
      rdy = q.size() < DEP;
      if (wr_valid && !rdy && e_stall != 16'hFFFF) e_stall++;
      if (pix_req) begin
        e_en = 1; e_we = 0; e_addr = pix_addr;
        exp_pd[t + 2 + LAT] = shadow[pix_addr];
      end else if (q.size() > 0) begin
        ent = q.pop_front();
        e_en = 1; e_we = 1; e_addr = ent.a; e_wd = ent.d;
        shadow[ent.a] = ent.d;
      end else begin
        e_en = 0; e_we = 0;
      end
      if (wr_valid && rdy) begin
        ent.a = wr_addr; ent.d = wr_data;
        q.push_back(ent);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : cmp
    bit            pv;
    logic [DW-1:0] pd;
    if (chk_on) begin
      pv = exp_pd.exists(cyc);
      pd = pv ? exp_pd[cyc] : '0;
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);
      chk("pix_valid", pix_valid, pv);
      chk("pix_data", pix_data, pd);
      chk("wr_ready", wr_ready, rst && q.size() < DEP);
      chk("fifo_level", fifo_level, q.size());
      chk("stall_cnt", stall_cnt, e_stall);
    end
  end

  // Valid-run statistics for the streaming test.
  int n_pv = 0;
  int run = 0;
  int maxrun = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      if (pix_valid) begin
        n_pv++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int nb;
    bit acc;
    for (int i = 0; i < 640; i++) begin
      bram[i]   = DW'(i * 7);
      shadow[i] = DW'(i * 7);
    end
    bram[5]   = 12'hF0A;
    shadow[5] = 12'hF0A;

    rst = 0; pix_req = 1; pix_addr = 18'h3; wr_valid = 1;
    wr_addr = 18'h7; wr_data = 12'h5A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_on = 1;
      chk("rst mem_en", mem_en, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst pix_valid", pix_valid, 0);
      chk("rst wr_ready", wr_ready, 0);
      chk("rst stall", stall_cnt, 0);
    end
    rst = 1; pix_req = 0; wr_valid = 0;
    tick();
    chk("post-rst wr_ready", wr_ready, 1);
    chk("post-rst level", fifo_level, 0);

    // Single read, latency 3.
    pix_req = 1; pix_addr = 18'h00005;
    tick();
    pix_req = 0;
    chk("rd mem_en", mem_en, 1);
    chk("rd mem_we", mem_we, 0);
    chk("rd mem_addr", mem_addr, 18'h00005);
    tick();
    chk("rd early valid", pix_valid, 0);
    tick();
    chk("rd valid", pix_valid, 1);
    chk("rd data", pix_data, 12'hF0A);
    tick();
    chk("rd valid drop", pix_valid, 0);

    // 640-pixel stream.
    nb = n_pv;
    for (int i = 0; i < 640; i++) begin
      pix_req = 1; pix_addr = AW'(i);
      tick();
    end
    pix_req = 0;
    repeat (5) tick();
    chk("stream count", n_pv - nb, 640);
    chk("stream run", maxrun, 640);

    // Write during blanking, then read it back.
    wr_valid = 1; wr_addr = 18'h10203; wr_data = 12'h123;
    tick();
    wr_valid = 0;
    chk("wr level", fifo_level, 1);
    tick();
    chk("wr mem_we", mem_we, 1);
    chk("wr mem_addr", mem_addr, 18'h10203);
    chk("wr mem_wdata", mem_wdata, 12'h123);
    tick();
    pix_req = 1; pix_addr = 18'h10203;
    tick();
    pix_req = 0;
    tick(); tick();
    chk("rb valid", pix_valid, 1);
    chk("rb data", pix_data, 12'h123);

    // Reads hold off writes until the FIFO fills.
    pix_req = 1; pix_addr = 18'h100;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      wr_valid = 1;
      wr_addr = 18'h20000 + AW'(k);
      wr_data = 12'h0A0 + DW'(k);
      acc = wr_ready;
      tick();
      if (acc) k++;
    end
    wr_valid = 0;
    chk("full accepted", k, 4);
    chk("full level", fifo_level, 4);
    chk("full ready", wr_ready, 0);
    chk("full stall", stall_cnt, 2);
    chk("full no we", mem_we, 0);
    pix_req = 0;
    tick();
    for (int j = 0; j < 4; j++) begin
      chk("drain we", mem_we, 1);
      chk("drain addr", mem_addr, 18'h20000 + AW'(j));
      chk("drain data", mem_wdata, 12'h0A0 + DW'(j));
      tick();
    end
    chk("drain done we", mem_we, 0);
    chk("drain level", fifo_level, 0);

    // Push and pop on the same cycle.
    pix_req = 1;
    wr_valid = 1; wr_addr = 18'h30000; wr_data = 12'h301;
    tick();
    wr_addr = 18'h30001; wr_data = 12'h302;
    tick();
    pix_req = 0;
    wr_addr = 18'h30002; wr_data = 12'h303;
    tick();
    wr_valid = 0; pix_req = 1;
    chk("pp level", fifo_level, 2);
    chk("pp we", mem_we, 1);
    chk("pp addr", mem_addr, 18'h30000);
    chk("pp data", mem_wdata, 12'h301);
    pix_req = 0;
    repeat (3) tick();
    chk("pp drain level", fifo_level, 0);

    // Stall counter saturation.
    pix_req = 1; pix_addr = 18'h200;
    wr_valid = 1; wr_addr = 18'h4000A; wr_data = 12'hABC;
    repeat (70000) tick();
    chk("sat stall", stall_cnt, 16'hFFFF);
    repeat (3) tick();
    chk("sat hold", stall_cnt, 16'hFFFF);
    chk("sat level", fifo_level, 4);

    // Reset with writes still buffered.
    wr_valid = 0; pix_req = 0;
    tick();
    chk("pre-rst level", fifo_level, 3);
    rst = 0;
    tick();
    chk("mid-rst we", mem_we, 0);
    chk("mid-rst en", mem_en, 0);
    chk("mid-rst stall", stall_cnt, 0);
    chk("mid-rst level", fifo_level, 0);
    chk("mid-rst ready", wr_ready, 0);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("after-rst we", mem_we, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
